// File: rtl/power_iter.sv
// Iterative fixed-point power unit: out = x^n in unsigned Q10.10, one multiply per clock.
// Define POWER_ITER_SAT_EN to saturate the accumulator at 20'hFFFFF once an overflow occurs.
module power_iter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [19:0] in_data_1,
    input  logic [2:0]  in_data_2,
    output logic        out_valid,
    output logic [19:0] out_data,
    output logic        out_ovf
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MULT,
        DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [19:0] r_x;
    logic [2:0]  r_n;
    logic [19:0] r_acc;
    logic [2:0]  r_cnt;
    logic        r_ovf;

    logic [39:0] w_prod;
    logic [29:0] w_q;
    logic        w_stepOvf;
    logic [19:0] w_accNext;

    assign w_prod    = {20'd0, r_acc} * {20'd0, r_x};
    assign w_q       = 30'(w_prod >> 10);
    assign w_stepOvf = |w_q[29:20];

`ifdef POWER_ITER_SAT_EN
    // Once saturated, stay pinned at full scale for the rest of the operation.
    assign w_accNext = (w_stepOvf || r_ovf) ? 20'hFFFFF : w_q[19:0];
`else
    assign w_accNext = w_q[19:0];
`endif

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (in_valid) w_next = LOAD;
            LOAD: if (!in_valid) w_next = MULT;
            MULT: if (r_cnt == 3'd0) w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: operand capture, iterative multiply and the registered result.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_x       <= 20'd0;
            r_n       <= 3'd0;
            r_acc     <= 20'd0;
            r_cnt     <= 3'd0;
            r_ovf     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 20'd0;
            out_ovf   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x <= in_data_1;
                        r_n <= in_data_2;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        r_x <= in_data_1;
                        r_n <= in_data_2;
                    end else begin
                        // n=0 yields 1.0; otherwise x itself is the first partial product.
                        r_acc <= (r_n == 3'd0) ? 20'h00400 : r_x;
                        r_cnt <= (r_n == 3'd0) ? 3'd0 : r_n - 3'd1;
                        r_ovf <= 1'b0;
                    end
                end
                MULT: begin
                    if (r_cnt != 3'd0) begin
                        r_acc <= w_accNext;
                        r_cnt <= r_cnt - 3'd1;
                        r_ovf <= r_ovf | w_stepOvf;
                    end else begin
                        out_data  <= r_acc;
                        out_ovf   <= r_ovf;
                        out_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/power_iter.md
POWER_ITER -- requirements
Module: power_iter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-high reset (asserted when 1).
REQ-003 SHALL have port in_valid, input, 1 bit: qualifies in_data_1 and in_data_2.
REQ-004 SHALL have port in_data_1, input, 20 bits: base x, unsigned Q10.10 (same format as the root block's out_data).
REQ-005 SHALL have port in_data_2, input, 3 bits: exponent n, 0..7.
REQ-006 SHALL have port out_valid, output, 1 bit: one-cycle result strobe.
REQ-007 SHALL have port out_data, output, 20 bits: x^n, unsigned Q10.10.
REQ-008 SHALL have port out_ovf, output, 1 bit: the integer part of some intermediate exceeded 1023.

Function
REQ-009 SHALL implement an FSM with states IDLE, LOAD, MULT and DONE.
REQ-010 SHALL, in IDLE, capture x and n and go to LOAD on a rising edge with in_valid=1; otherwise it SHALL stay in IDLE.
REQ-011 SHALL, in LOAD with in_valid=1, recapture x and n every edge (last value wins) and stay in LOAD.
REQ-012 SHALL, in LOAD with in_valid=0, go to MULT, set acc=x, cnt=n-1 and ovf=0; for n=0 it SHALL set acc=20'h00400 (1.0) and cnt=0.
REQ-013 SHALL, in MULT with cnt!=0, compute p=acc*x (40 bits) then q=p>>10 (truncate, no rounding), set acc=q[19:0] and cnt=cnt-1, and set ovf sticky if q[29:20]!=0.
REQ-014 SHALL, in MULT with cnt==0, go to DONE and register out_data=acc, out_ovf=ovf and out_valid=1.
REQ-015 SHALL, in DONE, clear out_valid and return to IDLE; out_data and out_ovf SHALL hold until the next result.
REQ-016 SHALL raise out_valid for exactly one cycle, after max(n,1) rising edges counted from the first edge on which LOAD samples in_valid=0.
REQ-017 SHALL ignore in_valid while in MULT or DONE; inputs are not queued.
REQ-018 SHALL use a 3-bit iteration counter that never wraps; the maximum is 6 multiplies, for n=7.
REQ-019 SHALL, for x=0 and n>=1, produce 0 with out_ovf=0; for n=1, produce x unchanged with no multiply.

Reset
REQ-020 SHALL, while rst_n=1, immediately force state=IDLE, out_valid=0, out_data=0, out_ovf=0, acc=0 and cnt=0, without waiting for clk.
REQ-021 SHALL, on reset mid-operation (LOAD or MULT), discard the operation and produce no out_valid.
REQ-022 SHALL leave IDLE only on the first edge after rst_n deasserts on which in_valid=1.

Configuration
REQ-023 SHALL, with macro POWER_ITER_SAT_EN defined, force acc to 20'hFFFFF from the overflowing step onward, so out_data=20'hFFFFF whenever out_ovf=1.
REQ-024 SHALL, without POWER_ITER_SAT_EN, keep acc=q[19:0] (wrap) after overflow; out_ovf SHALL still be reported.

Verification
REQ-025 SHALL cover: x=20'h00800 (2.0), n=3 -> out_data=20'h02000 (8.0), out_ovf=0, out_valid high 3 edges after in_valid falls.
REQ-026 SHALL cover: x=20'h00600 (1.5), n=2 -> out_data=20'h00900 (2.25); x=20'h00001, n=2 -> out_data=20'h00000 (truncation).
REQ-027 SHALL cover: n=0 with any x -> out_data=20'h00400, out_valid 1 edge after in_valid falls.
REQ-028 SHALL cover: x=20'h08000 (32.0), n=2 -> out_ovf=1; out_data=20'hFFFFF with POWER_ITER_SAT_EN, 20'h00000 without it.
REQ-029 SHALL cover: in_valid held 3 cycles with changing data -> last sample used; in_valid pulsed during MULT -> result unaffected.
REQ-030 SHALL cover: rst_n asserted mid-MULT for x=2.0, n=7 -> outputs zero immediately with no out_valid; the next x=2.0, n=2 -> 20'h01000.
